// File: rtl/instr_sequencer_if.sv
// Bus between the instruction sequencer and its environment: program-load
// port, start/flag inputs and the per-instruction datapath control outputs.
interface instr_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [15:0]       prog_data;
  logic              start;
  logic [4:0]        flags;
  logic [15:0]       ctrl_word;
  logic [15:0]       wr_en;
  logic              cin;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;

  // Environment side: loads the program, starts it, returns datapath flags.
  modport master (
    output prog_we, prog_addr, prog_data, start, flags,
    input  ctrl_word, wr_en, cin, pc, busy, done
  );

  // Sequencer side.
  modport slave (
    input  prog_we, prog_addr, prog_data, start, flags,
    output ctrl_word, wr_en, cin, pc, busy, done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Programmable control stage for the datapath. Holds a small program of
// 16-bit instruction words and, after a start pulse, steps through them at
// two cycles per instruction (FETCH then EXEC), presenting the control word,
// the one-hot register write enable and the carry-in for each one.
module instr_sequencer #(
  parameter int PROG_DEPTH = 16,
  parameter int ADDR_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  instr_sequencer_if.slave  bus
);

  localparam logic [15:0] NOP  = 16'h0000;
  localparam logic [15:0] HALT = 16'hFFFF;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PROG_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_mem [PROG_DEPTH];
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [15:0]       r_ir, w_ir_nxt;
  logic [15:0]       r_wr_en, w_wr_en_nxt;
  logic              r_cin, w_cin_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;

  logic [15:0]       w_fetch_word;
  logic              w_prog_wr;
  logic              w_unused_flags;

  assign w_fetch_word   = r_mem[r_pc];
  // The program is frozen while a run is in progress.
  assign w_prog_wr      = bus.prog_we && !r_busy;
  // Only the carry bit of the flag vector is consumed here.
  assign w_unused_flags = ^{bus.flags[4], bus.flags[2:0]};

  // Program memory: write port for loading, cleared to NOPs on reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the memory is reset on purpose -- an aborted run must leave an all-NOP program behind.
    if (reset) begin
      for (int i = 0; i < PROG_DEPTH; i++) r_mem[i] <= NOP;
    end else if (w_prog_wr) begin
      r_mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= NOP;
      r_wr_en <= '0;
      r_cin   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_wr_en <= w_wr_en_nxt;
      r_cin   <= w_cin_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state and next-output decode. The instruction register doubles as
  // the control-word register: it is loaded only for executable words and
  // cleared again when EXEC ends, so ctrl_word is zero outside EXEC.
  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_wr_en_nxt = r_wr_en;
    w_cin_nxt   = r_cin;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = '0;
          w_cin_nxt   = 1'b0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
        end
      end

      S_FETCH: begin
        if (w_fetch_word == HALT) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_EXEC;
          w_ir_nxt    = w_fetch_word;
          w_wr_en_nxt = (w_fetch_word == NOP) ? 16'h0000
                                              : (16'h0001 << w_fetch_word[3:0]);
        end
      end

      S_EXEC: begin
        w_ir_nxt    = NOP;
        w_wr_en_nxt = '0;
        w_cin_nxt   = bus.flags[3];
        if (r_pc == LAST_ADDR) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_FETCH;
          w_pc_nxt    = r_pc + ADDR_W'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.ctrl_word = r_ir;
  assign bus.wr_en     = r_wr_en;
  assign bus.cin       = r_cin;
  assign bus.pc        = r_pc;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: program loading, full and HALT-ended
// runs, carry propagation, busy protection, asynchronous abort, restart and
// the start/prog_we same-edge case. Expected values are hand-derived.
module tb_instr_sequencer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  instr_sequencer_if #(.ADDR_W(4)) bus ();

  instr_sequencer #(
    .PROG_DEPTH (16),
    .ADDR_W     (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.start     = 1'b0;
    bus.flags     = '0;
    reset         = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic load_word(input logic [3:0] addr, input logic [15:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr;
    bus.prog_data = data;
    tick();
    bus.prog_we   = 1'b0;
  endtask

  // Program 1 word k: {0, k-1, 5, k}, with word 0 a NOP.
  function automatic logic [15:0] prog1_word(input int k);
    if (k == 0) return 16'h0000;
    return {4'h0, 4'(k - 1), 4'h5, 4'(k)};
  endfunction

  task automatic load_prog1();
    for (int k = 1; k < 16; k++) load_word(4'(k), prog1_word(k));
  endtask

  // Pulse start and follow a full 16-instruction run to DONE at E32.
  // nops: program is all NOPs; inject: at EXEC of pc=2 pulse start and try
  // to overwrite mem[5], both of which must be ignored.
  task automatic run_full(input bit nops, input bit inject, input string tag);
    logic [15:0] exp_ctrl, exp_wr;
    bus.start = 1'b1;
    tick();                                   // E0
    bus.start = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.wr_en !== 16'h0 || bus.pc !== 4'd0) begin
      n_errors++;
      $display("FAIL %s start_accept: busy=%b done=%b wr_en=%h pc=%0d, expected busy=1 done=0 wr_en=0000 pc=0",
               tag, bus.busy, bus.done, bus.wr_en, bus.pc);
    end
    for (int k = 0; k < 16; k++) begin
      tick();                                 // E(2k+1): EXEC of pc=k
      exp_ctrl = nops ? 16'h0000 : prog1_word(k);
      exp_wr   = (exp_ctrl == 16'h0000) ? 16'h0000 : (16'h0001 << k);
      n_checks++;
      if (bus.pc !== 4'(k) || bus.ctrl_word !== exp_ctrl || bus.wr_en !== exp_wr ||
          bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_errors++;
        $display("FAIL %s exec k=%0d: pc=%0d ctrl=%h wr_en=%h busy=%b done=%b, expected pc=%0d ctrl=%h wr_en=%h busy=1 done=0",
                 tag, k, bus.pc, bus.ctrl_word, bus.wr_en, bus.busy, bus.done, k, exp_ctrl, exp_wr);
      end
      if (inject && k == 2) begin
        bus.start     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'd5;
        bus.prog_data = 16'h1234;
      end
      tick();                                 // E(2k+2)
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
      if (k < 15) begin
        n_checks++;
        if (bus.pc !== 4'(k + 1) || bus.ctrl_word !== 16'h0 || bus.wr_en !== 16'h0 || bus.busy !== 1'b1) begin
          n_errors++;
          $display("FAIL %s fetch k=%0d: pc=%0d ctrl=%h wr_en=%h busy=%b, expected pc=%0d ctrl=0000 wr_en=0000 busy=1",
                   tag, k + 1, bus.pc, bus.ctrl_word, bus.wr_en, bus.busy, k + 1);
        end
      end else begin
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pc !== 4'd15 ||
            bus.wr_en !== 16'h0 || bus.ctrl_word !== 16'h0) begin
          n_errors++;
          $display("FAIL %s done_e32: done=%b busy=%b pc=%0d wr_en=%h ctrl=%h, expected done=1 busy=0 pc=15 wr_en=0000 ctrl=0000",
                   tag, bus.done, bus.busy, bus.pc, bus.wr_en, bus.ctrl_word);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.flags = '0;
    tick();
    tick();
    n_checks++;
    if (bus.ctrl_word !== 16'h0 || bus.wr_en !== 16'h0 || bus.cin !== 1'b0 ||
        bus.pc !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: ctrl=%h wr_en=%h cin=%b pc=%0d busy=%b done=%b, expected all zero",
               bus.ctrl_word, bus.wr_en, bus.cin, bus.pc, bus.busy, bus.done);
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wr_en !== 16'h0) begin
      n_errors++;
      $display("FAIL idle_hold: busy=%b done=%b wr_en=%h, expected busy=0 done=0 wr_en=0000",
               bus.busy, bus.done, bus.wr_en);
    end
  endtask

  task automatic test_program1();
    do_reset();
    load_prog1();
    run_full(1'b0, 1'b0, "prog1");
  endtask

  // Restart from DONE must repeat the run identically.
  task automatic test_restart();
    run_full(1'b0, 1'b0, "restart");
  endtask

  task automatic test_program2();
    do_reset();
    load_word(4'd0, 16'h0051);
    load_word(4'd1, 16'h0152);
    load_word(4'd2, 16'hFFFF);
    bus.start = 1'b1;
    tick();                                   // E0
    bus.start = 1'b0;
    tick();                                   // E1: EXEC 0
    n_checks++;
    if (bus.ctrl_word !== 16'h0051 || bus.wr_en !== 16'h0002) begin
      n_errors++;
      $display("FAIL prog2_exec0: ctrl=%h wr_en=%h, expected ctrl=0051 wr_en=0002", bus.ctrl_word, bus.wr_en);
    end
    tick();                                   // E2: FETCH 1
    tick();                                   // E3: EXEC 1
    n_checks++;
    if (bus.ctrl_word !== 16'h0152 || bus.wr_en !== 16'h0004) begin
      n_errors++;
      $display("FAIL prog2_exec1: ctrl=%h wr_en=%h, expected ctrl=0152 wr_en=0004", bus.ctrl_word, bus.wr_en);
    end
    tick();                                   // E4: FETCH 2 (HALT)
    n_checks++;
    if (bus.wr_en !== 16'h0 || bus.busy !== 1'b1 || bus.pc !== 4'd2) begin
      n_errors++;
      $display("FAIL prog2_halt_fetch: wr_en=%h busy=%b pc=%0d, expected wr_en=0000 busy=1 pc=2",
               bus.wr_en, bus.busy, bus.pc);
    end
    tick();                                   // E5: DONE, no EXEC for HALT
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.pc !== 4'd2 ||
        bus.wr_en !== 16'h0 || bus.ctrl_word !== 16'h0) begin
      n_errors++;
      $display("FAIL prog2_done: done=%b busy=%b pc=%0d wr_en=%h ctrl=%h, expected done=1 busy=0 pc=2 wr_en=0000 ctrl=0000",
               bus.done, bus.busy, bus.pc, bus.wr_en, bus.ctrl_word);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b1 || bus.wr_en !== 16'h0 || bus.pc !== 4'd2) begin
      n_errors++;
      $display("FAIL prog2_done_hold: done=%b wr_en=%h pc=%0d, expected done=1 wr_en=0000 pc=2",
               bus.done, bus.wr_en, bus.pc);
    end
  endtask

  task automatic test_carry();
    do_reset();
    load_word(4'd0, 16'h0051);
    load_word(4'd1, 16'h0152);
    load_word(4'd2, 16'h0253);
    load_word(4'd3, 16'hFFFF);
    bus.start = 1'b1;
    tick();                                   // E0
    bus.start = 1'b0;
    tick();                                   // E1: EXEC 0
    n_checks++;
    if (bus.cin !== 1'b0) begin
      n_errors++;
      $display("FAIL carry_exec0: cin=%b, expected 0", bus.cin);
    end
    bus.flags = 5'b01000;                     // carry out of first instruction
    tick();                                   // E2: captured
    bus.flags = 5'b00000;
    tick();                                   // E3: EXEC 1
    n_checks++;
    if (bus.cin !== 1'b1) begin
      n_errors++;
      $display("FAIL carry_exec1: cin=%b, expected 1", bus.cin);
    end
    tick();                                   // E4: FETCH 2
    tick();                                   // E5: EXEC 2
    n_checks++;
    if (bus.cin !== 1'b0 || bus.wr_en !== 16'h0008) begin
      n_errors++;
      $display("FAIL carry_exec2: cin=%b wr_en=%h, expected cin=0 wr_en=0008", bus.cin, bus.wr_en);
    end
    bus.flags = 5'b10111;                     // every flag but carry
    tick();                                   // E6: captured
    bus.flags = 5'b00000;
    n_checks++;
    if (bus.cin !== 1'b0) begin
      n_errors++;
      $display("FAIL carry_other_flags: cin=%b, expected 0", bus.cin);
    end
  endtask

  task automatic test_busy_protect();
    do_reset();
    load_prog1();
    run_full(1'b0, 1'b1, "busy_inject");
    run_full(1'b0, 1'b0, "busy_readback");
  endtask

  task automatic test_reset_mid();
    do_reset();
    load_prog1();
    bus.start = 1'b1;
    tick();                                   // E0
    bus.start = 1'b0;
    repeat (7) tick();                        // E7: EXEC of pc=3
    n_checks++;
    if (bus.pc !== 4'd3 || bus.wr_en !== 16'h0008) begin
      n_errors++;
      $display("FAIL abort_setup: pc=%0d wr_en=%h, expected pc=3 wr_en=0008", bus.pc, bus.wr_en);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.wr_en !== 16'h0 || bus.ctrl_word !== 16'h0 || bus.busy !== 1'b0 || bus.pc !== 4'd0) begin
      n_errors++;
      $display("FAIL abort_async: wr_en=%h ctrl=%h busy=%b pc=%0d, expected wr_en=0000 ctrl=0000 busy=0 pc=0",
               bus.wr_en, bus.ctrl_word, bus.busy, bus.pc);
    end
    reset = 1'b0;
    tick();
    run_full(1'b1, 1'b0, "abort_nops");
  endtask

  task automatic test_same_edge();
    int cycles;
    do_reset();
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd0;
    bus.prog_data = 16'h0A53;
    bus.start     = 1'b1;
    tick();                                   // E0: write and start together
    bus.prog_we = 1'b0;
    bus.start   = 1'b0;
    tick();                                   // E1: EXEC 0 sees the new word
    n_checks++;
    if (bus.ctrl_word !== 16'h0A53 || bus.wr_en !== 16'h0008) begin
      n_errors++;
      $display("FAIL same_edge_exec: ctrl=%h wr_en=%h, expected ctrl=0A53 wr_en=0008", bus.ctrl_word, bus.wr_en);
    end
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    n_checks++;
    if (bus.done !== 1'b1 || cycles !== 31) begin
      n_errors++;
      $display("FAIL same_edge_done: done=%b after %0d cycles, expected done=1 after 31", bus.done, cycles);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_program1();
    test_restart();
    test_program2();
    test_carry();
    test_busy_protect();
    test_reset_mid();
    test_same_edge();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Upstream control stage for `datapath`. Holds a small loadable program memory of 16-bit instruction words.
- After a start pulse it steps through the program. For each instruction it presents the datapath control word, the one-hot register write enable, and the carry-in.
- Replaces hard-coded per-state control constants with a programmable sequence, so register-file/ALU tests become software-defined.

Parameters:
- PROG_DEPTH, 16, number of instruction words in program memory.
- ADDR_W, 4, program counter / program address width; PROG_DEPTH = 2**ADDR_W.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- prog_we  input  1  program memory write strobe
- prog_addr  input  ADDR_W  program memory write address
- prog_data  input  16  program memory write data
- start  input  1  single-cycle pulse; begins execution at address 0
- flags  input  5  datapath flag vector; flags[3] is carry
- ctrl_word  output  16  datapath control: [15:12] op, [11:8] A reg, [7:4] op ext, [3:0] B/dest reg
- wr_en  output  16  one-hot register-bank write enable
- cin  output  1  carry-in to datapath
- pc  output  ADDR_W  address of instruction currently fetched/executed
- busy  output  1  high from accepted start until DONE
- done  output  1  high in DONE state

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-high.
  - Reset forces state IDLE, pc=0, ir=0, ctrl_word=0, wr_en=0, cin=0, busy=0, done=0.
  - Reset clears all program words to 16'h0000 (NOP).
- Instruction classes:
  - NOP = 16'h0000: ctrl_word 0, wr_en 0.
  - HALT = 16'hFFFF.
  - Any other word is executable: wr_en = 1 << word[3:0].
- Program writes:
  - On an edge with prog_we=1 and busy=0: mem[prog_addr] <= prog_data.
  - prog_we is ignored while busy=1.
- State IDLE: ctrl_word=0, wr_en=0. On start=1 go to FETCH; pc<=0, cin<=0, busy<=1, done<=0.
- State FETCH: ir <= mem[pc]; ctrl_word=0, wr_en=0.
  - If mem[pc]==HALT: go to DONE. No EXEC cycle for HALT.
  - Otherwise go to EXEC.
- State EXEC, exactly one cycle per instruction:
  - ctrl_word=ir; wr_en=one-hot(ir[3:0]), or 0 if ir==NOP.
  - cin holds the carry captured from the previous instruction.
  - At the end of EXEC, cin <= flags[3], sampled on the EXEC cycle's closing edge.
  - If pc==PROG_DEPTH-1: go to DONE, with no wrap. Otherwise pc<=pc+1 and go to FETCH.
- State DONE:
  - busy=0, done=1, ctrl_word=0, wr_en=0; pc holds the last address.
  - start=1 restarts exactly as from IDLE.
- Outputs are registered and change only at the FETCH→EXEC and EXEC→next transitions. wr_en is never asserted outside EXEC.
- Timing:
  - Throughput is 2 cycles per instruction.
  - With start sampled at edge E0, the first EXEC cycle spans E1..E2.
  - A full 16-word program with no HALT reaches DONE at edge E32.
- start while busy=1 is ignored.
- start and prog_we on the same IDLE edge: the write commits, and the following FETCH observes it.
- Reset mid-operation aborts immediately; the program is cleared and a new load is required.

Test Plan:
- Program 1: mem[k] = {4'h0, k-1, 4'h5, k} for k=1..15 and mem[0]=NOP; pulse start. Required response:
  - EXEC wr_en sequence 0x0000, 0x0002, 0x0004 … 0x8000.
  - mem[1] EXEC shows ctrl_word 0x0051.
  - done=1 at edge E32.
- Program 2: mem[0]=0x0051, mem[1]=0x0152, mem[2]=0xFFFF. Required response:
  - Exactly two EXEC cycles, wr_en 0x0002 then 0x0004.
  - DONE with pc=2; wr_en never asserted for HALT.
- Carry: drive flags=5'b01000 during the first EXEC only. Required response: cin=1 during the second EXEC; cin=0 during the third EXEC (flags=0 in the second).
- Busy protection: during execution pulse start, and assert prog_we to addr 5 with 0x1234. Required response: pc sequence unaffected, and a post-run readback run shows mem[5] unchanged.
- Reset mid-run: assert reset during the EXEC of pc=3. Required response, immediately (asynchronous): wr_en=0, ctrl_word=0, busy=0, pc=0. A subsequent start with no reload executes NOPs to DONE at E32.
- Restart from DONE: pulse start in DONE. Required response: busy=1 and done=0 next cycle, and execution repeats identically.
